// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Shared 640x480 @ 60 Hz timing constants, derived totals and
//             sync windows, vertical phase encoding and a window helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25 MHz pixel clock
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    // Derived frame geometry (800 x 525 for the default mode)
    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Inclusive sync windows
    localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned H_SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1;
    localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned V_SYNC_END   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC - 1;

    // Vertical phase of the current line
    typedef enum logic [1:0] {
        V_VIS  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } v_phase_t;

    // Unsigned inclusive range test
    function automatic logic in_window(input logic [15:0] value,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_v_phase_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : vga_v_phase_fsm
//  Purpose  : Vertical phase state machine (visible / front porch / sync /
//             back porch) with line-in-phase counter and absolute line count.
//             Exposes next-state values so the top can register outputs that
//             reflect the line as updated on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_v_phase_fsm
    import vga_timing_pkg::*;
#(
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        adv_i,
    output v_phase_t    phase_d_o,
    output logic [15:0] line_q_o,
    output logic [9:0]  row_d_o,
    output logic        wrap_o
);

    localparam logic [15:0] c_VIS_LAST   = 16'(V_VISIBLE - 1);
    localparam logic [15:0] c_FP_LAST    = 16'(V_FRONT - 1);
    localparam logic [15:0] c_SYNC_LAST  = 16'(V_SYNC - 1);
    localparam logic [15:0] c_BP_LAST    = 16'(V_BACK - 1);
    localparam logic [15:0] c_FRAME_LAST = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    v_phase_t    phase_q, phase_d;
    logic [15:0] lip_q, lip_d;
    logic [15:0] line_q, line_d;
    logic [15:0] phase_last;
    logic        wrap;

    // Next phase, line-in-phase and absolute line; only moves on an advance pulse
    always_comb begin
        phase_d    = phase_q;
        lip_d      = lip_q;
        line_d     = line_q;
        wrap       = 1'b0;
        phase_last = c_VIS_LAST;
        case (phase_q)
            V_VIS:                  phase_last = c_VIS_LAST;
            V_FP:                   phase_last = c_FP_LAST;
            vga_timing_pkg::V_SYNC: phase_last = c_SYNC_LAST;
            V_BP:                   phase_last = c_BP_LAST;
            default:                phase_last = c_VIS_LAST;
        endcase
        if (adv_i) begin
            if (lip_q == phase_last) begin
                lip_d = '0;
                case (phase_q)
                    V_VIS:                  phase_d = V_FP;
                    V_FP:                   phase_d = vga_timing_pkg::V_SYNC;
                    vga_timing_pkg::V_SYNC: phase_d = V_BP;
                    V_BP:                   phase_d = V_VIS;
                    default:                phase_d = V_VIS;
                endcase
            end else begin
                lip_d = lip_q + 16'd1;
            end
            if (line_q == c_FRAME_LAST) begin
                line_d = '0;
                wrap   = 1'b1;
            end else begin
                line_d = line_q + 16'd1;
            end
        end
    end

    // Vertical state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= V_VIS;
            lip_q   <= '0;
            line_q  <= '0;
        end else begin
            phase_q <= phase_d;
            lip_q   <= lip_d;
            line_q  <= line_d;
        end
    end

    assign phase_d_o = phase_d;
    assign line_q_o  = line_q;
    assign row_d_o   = line_d[9:0];
    assign wrap_o    = wrap;

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_generator
//  Purpose  : Vertical line tracking plus registered VGA sync, blanking,
//             pixel-coordinate and frame-start outputs, driven by an external
//             horizontal counter and its line-advance pulse.
//  Options  : VGA_TIMING_CHECK_EN - enables the sticky timing_err monitor;
//             when undefined timing_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        enable_V_counter,
    input  logic [15:0] H_Count_Value,
    output logic [15:0] V_Count_Value,
    output logic        h_sync,
    output logic        v_sync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        timing_err
);

    localparam logic [15:0] c_H_VISIBLE = 16'(H_VISIBLE);
    localparam logic [15:0] c_H_TOTAL   = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [15:0] c_HS_START  = 16'(H_VISIBLE + H_FRONT);
    localparam logic [15:0] c_HS_END    = 16'(H_VISIBLE + H_FRONT + H_SYNC - 1);

    v_phase_t    phase_d;
    logic [9:0]  row_d;
    logic        wrap;

    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        frame_start_q;

    vga_v_phase_fsm #(
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_v_fsm (
        .clk_i     (clk_25MHz),
        .rst_ni    (rst_n),
        .adv_i     (enable_V_counter),
        .phase_d_o (phase_d),
        .line_q_o  (V_Count_Value),
        .row_d_o   (row_d),
        .wrap_o    (wrap)
    );

    // Output decode from this cycle's H and the vertical state being loaded now,
    // so the first pixel of a line already carries the new line number
    always_comb begin
        video_on_d = (H_Count_Value < c_H_VISIBLE) && (phase_d == V_VIS);
        h_sync_d   = (in_window(H_Count_Value, c_HS_START, c_HS_END) &&
                      (H_Count_Value < c_H_TOTAL)) ? SYNC_POL : ~SYNC_POL;
        v_sync_d   = (phase_d == vga_timing_pkg::V_SYNC) ? SYNC_POL : ~SYNC_POL;
        pixel_x_d  = video_on_d ? H_Count_Value[9:0] : 10'd0;
        pixel_y_d  = video_on_d ? row_d : 10'd0;
    end

    // Registered outputs
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= wrap;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_CHECK_EN
    logic timing_err_q, timing_err_d;

    // Sticky flag: line advance off H=0, or H beyond the line length
    always_comb begin
        timing_err_d = timing_err_q
                     | (enable_V_counter && (H_Count_Value != 16'd0))
                     | (H_Count_Value >= c_H_TOTAL);
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            timing_err_q <= 1'b0;
        end else begin
            timing_err_q <= timing_err_d;
        end
    end

    assign timing_err = timing_err_q;
`else
    assign timing_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_generator
//  Purpose  : Directed self-checking bench for vga_sync_generator (640x480).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_generator;

    logic        clk_25MHz;
    logic        rst_n;
    logic        enable_V_counter;
    logic [15:0] H_Count_Value;
    logic [15:0] V_Count_Value;
    logic        h_sync;
    logic        v_sync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic        timing_err;

    int vectors = 0;
    int errors  = 0;
    int exp_line = 0;

`ifdef VGA_TIMING_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    vga_sync_generator dut (
        .clk_25MHz        (clk_25MHz),
        .rst_n            (rst_n),
        .enable_V_counter (enable_V_counter),
        .H_Count_Value    (H_Count_Value),
        .V_Count_Value    (V_Count_Value),
        .h_sync           (h_sync),
        .v_sync           (v_sync),
        .video_on         (video_on),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .frame_start      (frame_start),
        .timing_err       (timing_err)
    );

    initial clk_25MHz = 1'b0;
    always #5 clk_25MHz = ~clk_25MHz;

    // Apply one H value / enable for one edge; outputs are sampled 1 ns later
    task automatic drive(input logic [15:0] h, input logic en);
        H_Count_Value    = h;
        enable_V_counter = en;
        @(posedge clk_25MHz);
        #1;
        enable_V_counter = 1'b0;
    endtask

    // Short line: enable at H=0 then one more pixel
    task automatic fast_line();
        drive(16'd0, 1'b1);
        exp_line = (exp_line + 1) % 525;
        drive(16'd1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_V_counter = 1'b0;
        H_Count_Value = 16'd0;
        repeat (3) @(posedge clk_25MHz);
        #1;
        vectors++; if (V_Count_Value !== 16'd0) begin errors++; $display("FAIL reset.V_Count_Value: got %0d expected 0", V_Count_Value); end
        vectors++; if (h_sync !== 1'b1) begin errors++; $display("FAIL reset.h_sync: got %0b expected 1", h_sync); end
        vectors++; if (v_sync !== 1'b1) begin errors++; $display("FAIL reset.v_sync: got %0b expected 1", v_sync); end
        vectors++; if (video_on !== 1'b0) begin errors++; $display("FAIL reset.video_on: got %0b expected 0", video_on); end
        vectors++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL reset.pixel: got %0d,%0d expected 0,0", pixel_x, pixel_y); end
        vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset.frame_start: got %0b expected 0", frame_start); end
        vectors++; if (timing_err !== 1'b0) begin errors++; $display("FAIL reset.timing_err: got %0b expected 0", timing_err); end
        rst_n = 1'b1;
        exp_line = 0;
    endtask

    // Full first line after reset (no enable at its H=0), then a wrap into line 1
    task automatic test_first_line();
        logic       e_vo;
        logic       e_hs;
        logic [9:0] e_px;
        for (int h = 0; h < 800; h++) begin
            drive(16'(h), 1'b0);
            e_vo = (h < 640);
            e_hs = !(h >= 656 && h <= 751);
            e_px = (h < 640) ? 10'(h) : 10'd0;
            vectors++; if (video_on !== e_vo) begin errors++; $display("FAIL line0.video_on h=%0d: got %0b expected %0b", h, video_on, e_vo); end
            vectors++; if (h_sync !== e_hs) begin errors++; $display("FAIL line0.h_sync h=%0d: got %0b expected %0b", h, h_sync, e_hs); end
            vectors++; if (pixel_x !== e_px) begin errors++; $display("FAIL line0.pixel_x h=%0d: got %0d expected %0d", h, pixel_x, e_px); end
            vectors++; if (pixel_y !== 10'd0 || V_Count_Value !== 16'd0) begin errors++; $display("FAIL line0.row h=%0d: got y=%0d V=%0d expected 0,0", h, pixel_y, V_Count_Value); end
        end
        drive(16'd0, 1'b1);
        exp_line = 1;
        vectors++; if (V_Count_Value !== 16'd1) begin errors++; $display("FAIL line1.V_Count_Value: got %0d expected 1", V_Count_Value); end
        vectors++; if (pixel_y !== 10'd1 || pixel_x !== 10'd0) begin errors++; $display("FAIL line1.pixel: got %0d,%0d expected 0,1", pixel_x, pixel_y); end
        vectors++; if (video_on !== 1'b1) begin errors++; $display("FAIL line1.video_on: got %0b expected 1", video_on); end
        drive(16'd1, 1'b0);
    endtask

    // Walk lines 2..524 checking vertical blanking, sync and line number
    task automatic test_vertical();
        logic       e_vo;
        logic       e_vs;
        logic [9:0] e_py;
        for (int l = 2; l < 525; l++) begin
            drive(16'd0, 1'b1);
            exp_line = l;
            e_vo = (l < 480);
            e_vs = !(l == 490 || l == 491);
            e_py = (l < 480) ? 10'(l) : 10'd0;
            vectors++; if (V_Count_Value !== 16'(l)) begin errors++; $display("FAIL vert.V_Count_Value: got %0d expected %0d", V_Count_Value, l); end
            vectors++; if (video_on !== e_vo) begin errors++; $display("FAIL vert.video_on line=%0d: got %0b expected %0b", l, video_on, e_vo); end
            vectors++; if (v_sync !== e_vs) begin errors++; $display("FAIL vert.v_sync line=%0d: got %0b expected %0b", l, v_sync, e_vs); end
            vectors++; if (pixel_y !== e_py) begin errors++; $display("FAIL vert.pixel_y line=%0d: got %0d expected %0d", l, pixel_y, e_py); end
            vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL vert.frame_start line=%0d: got %0b expected 0", l, frame_start); end
            drive(16'd1, 1'b0);
        end
    endtask

    // Wrap from 524 to 0, single-cycle frame_start, 525 lines between pulses
    task automatic test_wrap();
        int cycles;
        int pulses;
        drive(16'd0, 1'b1);
        exp_line = 0;
        vectors++; if (V_Count_Value !== 16'd0) begin errors++; $display("FAIL wrap.V_Count_Value: got %0d expected 0", V_Count_Value); end
        vectors++; if (frame_start !== 1'b1) begin errors++; $display("FAIL wrap.frame_start: got %0b expected 1", frame_start); end
        vectors++; if (video_on !== 1'b1 || v_sync !== 1'b1) begin errors++; $display("FAIL wrap.phase: got vo=%0b vs=%0b expected 1,1", video_on, v_sync); end
        drive(16'd1, 1'b0);
        vectors++; if (frame_start !== 1'b0) begin errors++; $display("FAIL wrap.frame_start_width: got %0b expected 0", frame_start); end
        cycles = 1;
        pulses = 0;
        for (int l = 1; l <= 525; l++) begin
            drive(16'd0, 1'b1);
            cycles++;
            if (frame_start === 1'b1) pulses++;
            if (frame_start === 1'b1 || l == 525) begin
                vectors++; if (l != 525 || cycles != 1050) begin errors++; $display("FAIL wrap.interval: got line %0d after %0d cycles expected line 525 after 1050", l, cycles); end
            end
            drive(16'd1, 1'b0);
            cycles++;
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL wrap.pulse_count: got %0d expected 1", pulses); end
        exp_line = 0;
    endtask

    // Line advance with H != 0
    task automatic test_timing_err();
        drive(16'd5, 1'b1);
        exp_line = exp_line + 1;
        vectors++; if (V_Count_Value !== 16'(exp_line)) begin errors++; $display("FAIL terr.V_Count_Value: got %0d expected %0d", V_Count_Value, exp_line); end
        vectors++; if (timing_err !== EXP_ERR) begin errors++; $display("FAIL terr.set: got %0b expected %0b", timing_err, EXP_ERR); end
        drive(16'd6, 1'b0);
        drive(16'd0, 1'b0);
        vectors++; if (timing_err !== EXP_ERR) begin errors++; $display("FAIL terr.sticky: got %0b expected %0b", timing_err, EXP_ERR); end
    endtask

    // H beyond the line: blanked, sync inactive, line unchanged
    task automatic test_h_overrange();
        logic [15:0] hv [2];
        hv[0] = 16'd800;
        hv[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            drive(hv[i], 1'b0);
            vectors++; if (video_on !== 1'b0 || h_sync !== 1'b1) begin errors++; $display("FAIL hover.blank h=%0d: got vo=%0b hs=%0b expected 0,1", hv[i], video_on, h_sync); end
            vectors++; if (V_Count_Value !== 16'(exp_line)) begin errors++; $display("FAIL hover.V_Count_Value: got %0d expected %0d", V_Count_Value, exp_line); end
            vectors++; if (timing_err !== EXP_ERR) begin errors++; $display("FAIL hover.timing_err: got %0b expected %0b", timing_err, EXP_ERR); end
        end
    endtask

    // Asynchronous reset at line 300, H=400, then restart from line 0
    task automatic test_reset_mid_frame();
        while (exp_line != 300) fast_line();
        drive(16'd400, 1'b0);
        vectors++; if (video_on !== 1'b1 || pixel_x !== 10'd400 || pixel_y !== 10'd300) begin errors++; $display("FAIL midrst.pre: got vo=%0b x=%0d y=%0d expected 1,400,300", video_on, pixel_x, pixel_y); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (V_Count_Value !== 16'd0) begin errors++; $display("FAIL midrst.V_Count_Value: got %0d expected 0", V_Count_Value); end
        vectors++; if (video_on !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL midrst.video: got vo=%0b x=%0d y=%0d expected 0,0,0", video_on, pixel_x, pixel_y); end
        vectors++; if (h_sync !== 1'b1 || v_sync !== 1'b1 || frame_start !== 1'b0 || timing_err !== 1'b0) begin errors++; $display("FAIL midrst.flags: got hs=%0b vs=%0b fs=%0b te=%0b expected 1,1,0,0", h_sync, v_sync, frame_start, timing_err); end
        @(posedge clk_25MHz);
        #1;
        rst_n = 1'b1;
        exp_line = 0;
        drive(16'd0, 1'b0);
        vectors++; if (V_Count_Value !== 16'd0 || video_on !== 1'b1 || pixel_y !== 10'd0) begin errors++; $display("FAIL midrst.restart: got V=%0d vo=%0b y=%0d expected 0,1,0", V_Count_Value, video_on, pixel_y); end
        fast_line();
        vectors++; if (V_Count_Value !== 16'd1 || frame_start !== 1'b0) begin errors++; $display("FAIL midrst.next_line: got V=%0d fs=%0b expected 1,0", V_Count_Value, frame_start); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_vertical();
        test_wrap();
        test_timing_err();
        test_h_overrange();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
